// File: rtl/tpdf_dither_pkg.sv
// dither_pkg: shared definitions for the tpdf_dither requantizer.
//
// Contents:
//   state_e        FSM state encoding (IDLE, NOISE1, NOISE2, SUM, OUT)
//   clog2_min1()   ceil(log2(n)) clamped to at least 1, used for channel tag width
//   widths_legal() parameter legality check for the sample/noise widths
package dither_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_NOISE1 = 3'd1,
    ST_NOISE2 = 3'd2,
    ST_SUM    = 3'd3,
    ST_OUT    = 3'd4
  } state_e;

  // A single-channel build still needs a 1-bit tag, hence the floor of 1.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    if (w < 1) w = 1;
    return w;
  endfunction

  // Output must be strictly narrower than the input, and the noise word
  // must be wide enough to supply D = iw - ow dither bits.
  function automatic bit widths_legal(input int iw, input int ow, input int rw);
    return (ow > 0) && (ow < iw) && (rw >= (iw - ow));
  endfunction

endpackage

// File: rtl/tpdf_dither_round_saturate.sv
// round_saturate: combinational dither add, round-half-up and clamp.
//
// Computes, in INPUT_WIDTH+2 signed bits:
//   sum = sample + tpdf + 2^(D-1);  q = sum >>> D;  out = clamp(q) to OUTPUT_WIDTH
//
// Ports:
//   sample_i  signed INPUT_WIDTH input sample
//   tpdf_i    signed D+1 bit triangular dither value, range +/-(2^D-1)
//   out_o     signed OUTPUT_WIDTH rounded and saturated result
module round_saturate #(
  parameter int INPUT_WIDTH  = 24,
  parameter int OUTPUT_WIDTH = 16,
  localparam int D           = INPUT_WIDTH - OUTPUT_WIDTH,
  localparam int AW          = INPUT_WIDTH + 2
) (
  input  logic signed [INPUT_WIDTH-1:0]  sample_i,
  input  logic signed [D:0]              tpdf_i,
  output logic signed [OUTPUT_WIDTH-1:0] out_o
);

  localparam logic signed [AW-1:0] HALF = AW'(1) << (D - 1);
  localparam logic signed [AW-1:0] MAXV = {{(AW-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] q;

  // Two guard bits cover the worst case of full-scale input plus full-scale
  // dither plus the rounding half, so the add itself never wraps.
  always_comb begin
    sum   = $signed({{2{sample_i[INPUT_WIDTH-1]}}, sample_i})
          + $signed({{(AW-D-1){tpdf_i[D]}}, tpdf_i})
          + HALF;
    q     = sum >>> D;
    out_o = q[OUTPUT_WIDTH-1:0];
    if (q > MAXV) begin
      out_o = MAXV[OUTPUT_WIDTH-1:0];
    end else if (q < MINV) begin
      out_o = MINV[OUTPUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/tpdf_dither.sv
// tpdf_dither: multichannel TPDF dither and requantizer, placed directly
// downstream of a `randomizer`. Each accepted sample fetches two noise words,
// forms triangular dither r1 - r2, adds it, rounds half-up, saturates and
// presents the narrowed sample with its channel tag on a valid/ready output.
//
// Configuration macro: TPDF_DITHER_EN
//   defined   : IDLE -> NOISE1 -> NOISE2 -> SUM -> OUT, two noise requests per sample
//   undefined : IDLE -> SUM -> OUT, no noise requests, plain rounding + saturation
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_d/in_ch/in_valid   input sample, channel tag, valid
//   in_ready              registered, high while waiting for a sample
//   out_d/out_ch          registered result and copied tag
//   out_valid/out_ready   output handshake
//   rndm_ch/rndm_ready    noise request towards the randomizer
//   rndm_out              registered noise word, valid one cycle after rndm_ready
module tpdf_dither
  import dither_pkg::*;
#(
  parameter int NR_CHANNELS    = 1,
  parameter int INPUT_WIDTH    = 24,
  parameter int OUTPUT_WIDTH   = 16,
  parameter int RNDM_WIDTH     = 32,
  localparam int CHANNEL_WIDTH = clog2_min1(NR_CHANNELS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [INPUT_WIDTH-1:0]   in_d,
  input  logic [CHANNEL_WIDTH-1:0] in_ch,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [OUTPUT_WIDTH-1:0]  out_d,
  output logic [CHANNEL_WIDTH-1:0] out_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CHANNEL_WIDTH-1:0] rndm_ch,
  output logic                     rndm_ready,
  input  logic [RNDM_WIDTH-1:0]    rndm_out
);

  localparam int D = INPUT_WIDTH - OUTPUT_WIDTH;

  generate
    if (!widths_legal(INPUT_WIDTH, OUTPUT_WIDTH, RNDM_WIDTH)) begin : g_illegal_widths
      $error("tpdf_dither: need OUTPUT_WIDTH < INPUT_WIDTH and RNDM_WIDTH >= INPUT_WIDTH-OUTPUT_WIDTH");
    end
  endgenerate

  state_e                   state_q, state_d;
  logic                     in_ready_q, in_ready_d;
  logic [INPUT_WIDTH-1:0]   sample_q, sample_d;
  logic [CHANNEL_WIDTH-1:0] ch_q, ch_d;
  logic [OUTPUT_WIDTH-1:0]  out_d_q, out_d_d;
  logic [CHANNEL_WIDTH-1:0] out_ch_q, out_ch_d;
  logic                     out_valid_q, out_valid_d;

  logic signed [D:0]            tpdf;
  logic signed [OUTPUT_WIDTH-1:0] rs_out;

`ifdef TPDF_DITHER_EN
  // One extra bit so NR_CHANNELS == 2**CHANNEL_WIDTH is still representable.
  localparam logic [CHANNEL_WIDTH:0] NR_CH_LIMIT = (CHANNEL_WIDTH+1)'(NR_CHANNELS);

  logic [D-1:0] r1_q, r1_d;
  logic [D-1:0] r2;
  logic         ch_ok;
  logic         noise_state;

  assign ch_ok       = ({1'b0, ch_q} < NR_CH_LIMIT);
  assign noise_state = (state_q == ST_NOISE1) || (state_q == ST_NOISE2);
  assign r2          = rndm_out[RNDM_WIDTH-1 -: D];

  // An out-of-range tag has no randomizer behind it, so it neither requests
  // noise nor gets any: the sample is still rounded with the same latency.
  assign rndm_ready = noise_state && ch_ok;
  assign rndm_ch    = noise_state ? ch_q : '0;
  assign tpdf       = ch_ok ? $signed({1'b0, r1_q} - {1'b0, r2}) : '0;
`else
  logic unused_rndm;

  assign rndm_ready  = 1'b0;
  assign rndm_ch     = '0;
  assign tpdf        = '0;
  assign unused_rndm = ^rndm_out;
`endif

  round_saturate #(
    .INPUT_WIDTH (INPUT_WIDTH),
    .OUTPUT_WIDTH(OUTPUT_WIDTH)
  ) u_round_saturate (
    .sample_i(sample_q),
    .tpdf_i  (tpdf),
    .out_o   (rs_out)
  );

  // Next-state logic. in_ready is registered: it is re-armed every cycle in
  // IDLE (so it rises one edge after reset release) and on the output
  // handshake edge, and dropped on the accept edge.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    sample_d    = sample_q;
    ch_d        = ch_q;
    out_d_d     = out_d_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
`ifdef TPDF_DITHER_EN
    r1_d        = r1_q;
`endif
    case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          sample_d   = in_d;
          ch_d       = in_ch;
          in_ready_d = 1'b0;
`ifdef TPDF_DITHER_EN
          state_d    = ST_NOISE1;
`else
          state_d    = ST_SUM;
`endif
        end
      end
      ST_NOISE1: begin
        state_d = ST_NOISE2;
      end
      ST_NOISE2: begin
`ifdef TPDF_DITHER_EN
        r1_d    = rndm_out[RNDM_WIDTH-1 -: D];
`endif
        state_d = ST_SUM;
      end
      ST_SUM: begin
        out_d_d     = rs_out;
        out_ch_d    = ch_q;
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset discards any in-flight sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      sample_q    <= '0;
      ch_q        <= '0;
      out_d_q     <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
`ifdef TPDF_DITHER_EN
      r1_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      sample_q    <= sample_d;
      ch_q        <= ch_d;
      out_d_q     <= out_d_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
`ifdef TPDF_DITHER_EN
      r1_q        <= r1_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_d     = out_d_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_tpdf_dither.sv
// tb_tpdf_dither: directed, table-driven bench for tpdf_dither with
// INPUT 24, OUTPUT 16 (D = 8), RNDM 32, NR_CHANNELS = 3 so that tag 3 is
// out of range. A small randomizer model returns forced top bytes r1 then r2.
// Builds with or without TPDF_DITHER_EN; expectations follow the macro.
module tb_tpdf_dither;

  localparam int IW = 24;
  localparam int OW = 16;
  localparam int RW = 32;
  localparam int NCH = 3;
  localparam int CW = 2;
`ifdef TPDF_DITHER_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 1;
`endif

  typedef struct {
    logic [IW-1:0] d;
    logic [CW-1:0] ch;
    logic [7:0]    r1;
    logic [7:0]    r2;
    logic [OW-1:0] expD;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] in_d = '0;
  logic [CW-1:0] in_ch = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [OW-1:0] out_d;
  logic [CW-1:0] out_ch;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] rndm_ch;
  logic          rndm_ready;
  logic [RW-1:0] rndm_out;

  logic [7:0]    forceR1 = 8'h00;
  logic [7:0]    forceR2 = 8'h00;
  logic [CW-1:0] expCh = '0;
  logic          rndmSel;
  int            reqCount = 0;
  int            chBad = 0;

  int total = 0;
  int bad = 0;

  vec_t vecs[16];
  int   nVec = 0;

  tpdf_dither #(
    .NR_CHANNELS (NCH),
    .INPUT_WIDTH (IW),
    .OUTPUT_WIDTH(OW),
    .RNDM_WIDTH  (RW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_d      (in_d),
    .in_ch     (in_ch),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_d     (out_d),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rndm_ch   (rndm_ch),
    .rndm_ready(rndm_ready),
    .rndm_out  (rndm_out)
  );

  always #5 clk = ~clk;

  // Randomizer stand-in: registered output, alternating forced r1 / r2 in
  // the top byte with non-zero filler below to catch wrong bit selection.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rndmSel  <= 1'b0;
      rndm_out <= '0;
    end else if (rndm_ready) begin
      rndm_out <= rndmSel ? {forceR2, 24'h5A5A5A} : {forceR1, 24'hA5A5A5};
      rndmSel  <= ~rndmSel;
    end
  end

  // Count every noise request and any request made with the wrong tag.
  always @(posedge clk) begin
    if (rndm_ready) begin
      reqCount <= reqCount + 1;
      if (rndm_ch != expCh) chBad <= chBad + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic [IW-1:0] d, input logic [CW-1:0] ch,
                        input logic [7:0] r1, input logic [7:0] r2, input logic [OW-1:0] e);
    vecs[nVec] = '{d, ch, r1, r2, e};
    nVec++;
  endtask

  function automatic int expRequests(input logic [CW-1:0] ch);
`ifdef TPDF_DITHER_EN
    return (int'(ch) < NCH) ? 2 : 0;
`else
    return (ch == ch) ? 0 : 0;
`endif
  endfunction

  // Runs one sample through. With releaseOut=0 it returns while out_valid
  // is still held so the caller can exercise back-pressure.
  task automatic applyStimulus(input vec_t v, input bit releaseOut);
    int guard;
    int lat;
    int reqBefore;
    int chBadBefore;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checkOutput("inReadyWait", 32'(in_ready), 32'd1);
      return;
    end
    forceR1     = v.r1;
    forceR2     = v.r2;
    expCh       = v.ch;
    reqBefore   = reqCount;
    chBadBefore = chBad;
    in_d        = v.d;
    in_ch       = v.ch;
    in_valid    = 1'b1;
    out_ready   = releaseOut;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(EXP_LAT));
    checkOutput("outD", 32'(out_d), 32'(v.expD));
    checkOutput("outCh", 32'(out_ch), 32'(v.ch));
    checkOutput("rndmRequests", 32'(reqCount - reqBefore), 32'(expRequests(v.ch)));
    checkOutput("rndmChBad", 32'(chBad - chBadBefore), 32'd0);
    if (releaseOut) begin
      @(negedge clk);
      checkOutput("postHsValid", 32'(out_valid), 32'd0);
      checkOutput("postHsInReady", 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    vec_t v;
    int   holdBad;
    bit   sawValid;

    // Plain rounding / saturation vectors: r1 == r2 gives zero dither.
    addVec(24'h000080, 2'd0, 8'h3C, 8'h3C, 16'h0001);
    addVec(24'h00007F, 2'd1, 8'h3C, 8'h3C, 16'h0000);
    addVec(24'h7FFFFF, 2'd2, 8'h3C, 8'h3C, 16'h7FFF);
    addVec(24'h800000, 2'd0, 8'h3C, 8'h3C, 16'h8000);
    addVec(24'h123456, 2'd1, 8'h3C, 8'h3C, 16'h1234);
    addVec(24'h1234C0, 2'd2, 8'h3C, 8'h3C, 16'h1235);
    addVec(24'hFFFF80, 2'd0, 8'h3C, 8'h3C, 16'h0000);
    addVec(24'hFFFF7F, 2'd1, 8'h3C, 8'h3C, 16'hFFFF);
    addVec(24'h7FFF80, 2'd2, 8'h3C, 8'h3C, 16'h7FFF);
    // Out-of-range tag: noise would be +255, but it must be ignored.
    addVec(24'h000080, 2'd3, 8'hFF, 8'h00, 16'h0001);
`ifdef TPDF_DITHER_EN
    addVec(24'h000000, 2'd1, 8'hFF, 8'h00, 16'h0001);
    addVec(24'h000000, 2'd2, 8'h00, 8'hFF, 16'hFFFF);
    addVec(24'h7FFF7F, 2'd0, 8'hFF, 8'h00, 16'h7FFF);
    addVec(24'h800000, 2'd1, 8'h00, 8'hFF, 16'h8000);
    addVec(24'h000100, 2'd2, 8'h10, 8'h90, 16'h0001);
`endif

    // Reset values while rst_n is held low.
    repeat (3) @(negedge clk);
    checkOutput("rstInReady", 32'(in_ready), 32'd0);
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstOutD", 32'(out_d), 32'd0);
    checkOutput("rstOutCh", 32'(out_ch), 32'd0);
    checkOutput("rstRndmReady", 32'(rndm_ready), 32'd0);
    checkOutput("rstRndmCh", 32'(rndm_ch), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("inReadyAfterRelease", 32'(in_ready), 32'd1);

    for (int i = 0; i < nVec; i++) begin
      applyStimulus(vecs[i], 1'b1);
    end

    // Back-pressure: output and tag must hold, no new sample accepted.
    v = '{24'h001280, 2'd2, 8'h00, 8'h00, 16'h0013};
    applyStimulus(v, 1'b0);
    holdBad = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_d !== 16'h0013 || out_ch !== 2'd2 || out_valid !== 1'b1 || in_ready !== 1'b0)
        holdBad++;
    end
    checkOutput("holdStable", 32'(holdBad), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("holdRelValid", 32'(out_valid), 32'd0);
    checkOutput("holdRelInReady", 32'(in_ready), 32'd1);

    // Reset in the middle of a sample (NOISE2 when dithering, SUM otherwise).
    forceR1  = 8'h40;
    forceR2  = 8'h00;
    expCh    = 2'd1;
    in_d     = 24'h005580;
    in_ch    = 2'd1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
`ifdef TPDF_DITHER_EN
    @(negedge clk);
    checkOutput("midRndmReady", 32'(rndm_ready), 32'd1);
`endif
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midRstInReady", 32'(in_ready), 32'd0);
    checkOutput("midRstOutValid", 32'(out_valid), 32'd0);
    checkOutput("midRstOutD", 32'(out_d), 32'd0);
    checkOutput("midRstOutCh", 32'(out_ch), 32'd0);
    checkOutput("midRstRndmReady", 32'(rndm_ready), 32'd0);
    checkOutput("midRstRndmCh", 32'(rndm_ch), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sawValid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("noValidAfterReset", 32'(sawValid), 32'd0);

    // The next sample after the aborted one completes normally.
    v = '{24'h005580, 2'd1, 8'h20, 8'h20, 16'h0056};
    applyStimulus(v, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
